// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART word-to-byte arbiter: FSM encoding, byte width
// and the byte-select helper.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Byte idx of a 32-bit word, byte 0 being the least significant.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [31:0] word,
                                                  input logic [1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter2.sv
// Two-requester arbiter with a round-robin priority pointer.
// Define UART_ARB_FIXED_PRIO_EN to replace the pointer with fixed requester-0 priority.
module uart_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic [1:0] i_valid,
  output logic [1:0] o_ready,
  output logic       o_gnt_idx,
  output logic       o_accept
);

  logic w_winner;

`ifdef UART_ARB_FIXED_PRIO_EN
  logic w_unused_clk_rst;

  assign w_unused_clk_rst = clk | reset;
  assign w_winner         = ~i_valid[0];
`else
  // r_prio names the requester that wins the next tie; it moves only on accept.
  logic r_prio;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prio <= 1'b0;
    end else if (o_accept) begin
      r_prio <= ~w_winner;
    end
  end

  assign w_winner = (&i_valid) ? r_prio : i_valid[1];
`endif

  assign o_accept  = i_enable & (|i_valid);
  assign o_gnt_idx = w_winner;
  assign o_ready   = {o_accept & w_winner, o_accept & ~w_winner};

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two 32-bit word sources onto a byte transmitter, LSB byte first.
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed priority in the arbiter.
//
// state | meaning
// IDLE  | no word held; accept a request this cycle
// START | one-cycle tx_start for byte[counter]
// WAIT  | waiting for tx_done of the current byte
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [31:0]       req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [31:0]       req1_data,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              grant,
  output logic              word_done
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_grant;

  logic        w_enable;
  logic [1:0]  w_ready;
  logic        w_gnt_idx;
  logic        w_accept;
  logic [31:0] w_sel_data;
  logic        w_byte_done;
  logic        w_last;

  // Gating with reset keeps a held request from being accepted while reset is low.
  assign w_enable = reset & (r_state == ST_IDLE);

  uart_rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (w_enable),
    .i_valid   ({req1_valid, req0_valid}),
    .o_ready   (w_ready),
    .o_gnt_idx (w_gnt_idx),
    .o_accept  (w_accept)
  );

  assign w_sel_data  = w_gnt_idx ? req1_data : req0_data;
  assign w_byte_done = (r_state == ST_WAIT) & tx_done;
  assign w_last      = (r_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_word  <= 32'd0;
      r_grant <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_word  <= w_sel_data;
            r_grant <= w_gnt_idx;
            r_cnt   <= 2'd0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= r_cnt + 2'd1;
              r_state <= ST_START;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];
  assign tx_start   = reset & (r_state == ST_START);
  assign tx_data    = word_byte(r_word, r_cnt);
  assign busy       = (r_state != ST_IDLE);
  assign grant      = r_grant;
  assign word_done  = reset & w_byte_done & w_last;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4, meaning bytes sent per 32-bit word (1..4), LSB byte first.
REQ-002 SHALL have ports:
  clk  in  1  single clock; all logic on its rising edge.
  reset  in  1  synchronous, active-low reset.
  req0_valid  in  1  requester 0 has a word pending.
  req0_data  in  32  requester 0 word.
  req0_ready  out  1  requester 0 word accepted this cycle.
  req1_valid  in  1  requester 1 has a word pending.
  req1_data  in  32  requester 1 word.
  req1_ready  out  1  requester 1 word accepted this cycle.
  tx_start  out  1  one-cycle start pulse to the byte transmitter.
  tx_data  out  8  byte to transmit; stable from tx_start until tx_done.
  tx_done  in  1  one-cycle pulse from the transmitter, byte finished.
  busy  out  1  a word is in flight.
  grant  out  1  index of the requester being served; valid while busy.
  word_done  out  1  one-cycle pulse, last byte of the word finished.

Function
REQ-003 SHALL implement FSM states IDLE, START, WAIT.
REQ-004 IDLE: if any reqN_valid, SHALL assert the winner's reqN_ready combinationally in that cycle, capture reqN_data, set grant, clear byte counter, and go to START.
REQ-005 Only one reqN_ready SHALL be high in any cycle; ready SHALL be low outside IDLE.
REQ-006 START: SHALL drive tx_start=1 for exactly one cycle with tx_data = captured word byte[counter], then go to WAIT.
REQ-007 WAIT: on tx_done, if counter < NUM_BYTES-1, SHALL increment counter and go to START; otherwise SHALL pulse word_done in the same cycle and go to IDLE.
REQ-008 Minimum spacing SHALL be: accept at cycle T, tx_start at T+1, next tx_start one cycle after each tx_done.
REQ-009 tx_done while in IDLE or START SHALL be ignored.
REQ-010 busy SHALL be high in START and WAIT, low in IDLE.
REQ-011 Round-robin: when both valid, the requester not served last SHALL win; after reset requester 0 SHALL have priority.
REQ-012 A single valid requester SHALL be granted regardless of pointer; the pointer SHALL update only on accept.
REQ-013 Deassertion or change of reqN_valid/reqN_data after accept SHALL NOT affect the word in flight.
REQ-014 A word SHALL be accepted in the same cycle the FSM re-enters IDLE only on the following cycle (no back-to-back accept inside the word_done cycle).

Reset
REQ-015 With reset low at a clk edge, SHALL go to IDLE, counter=0, pointer=requester 0, captured word=0.
REQ-016 Outputs in reset SHALL be: tx_start=0, tx_data=0, busy=0, grant=0, word_done=0, req0_ready=0, req1_ready=0.
REQ-017 Reset mid-word SHALL abort it; no further tx_start for that word.

Configuration
REQ-018 Macro UART_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win on simultaneous valid (no pointer); when undefined, REQ-011 round-robin applies.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (IDLE/START/WAIT) and the byte width constant 8.
REQ-020 Arbitration (pointer plus grant logic) SHALL be a sub-module named uart_rr_arbiter2; the FSM and byte mux stay in the top.

Verification
REQ-021 Single word: req0_valid with 0xA1B2C3D4, tx_done 16 cycles after each tx_start -> tx_data 0xD4, 0xC3, 0xB2, 0xA1 in order; one word_done pulse; busy falls the next cycle.
REQ-022 Contention: req0 and req1 valid together from reset, words 0x11111111 and 0x22222222 -> req0 served first, then req1; without the macro a second req0 word arriving before req1 finishes waits until req1 completes.
REQ-023 Macro defined: both requesters held valid for 3 words -> three req0 words sent, no req1 accept.
REQ-024 Spurious done: tx_done pulse in IDLE, and in the START cycle -> no counter change, no tx_start, no word_done.
REQ-025 Reset mid-word: reset low after the second tx_done of 0xCAFEBABE -> all outputs at reset values next edge; no further tx_start; next req1 word starts at its byte 0.
REQ-026 NUM_BYTES=1: word 0x000000FF -> exactly one tx_start with tx_data 0xFF, then word_done.
